// File: rtl/musicbox_input_conditioner.sv
// musicbox_input_conditioner - synchronizes, normalizes and debounces the music keys and control buttons,
// and runs the UI mode state machine.
module musicbox_input_conditioner #(
  parameter int NUM_KEYS        = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                max10Board_50MhzClock,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] raw_keys,
  input  logic                raw_playSong0,
  input  logic                raw_playSong1,
  input  logic                raw_makeRecording,
  input  logic                raw_playRecording,
  input  logic                song_done,
  input  logic                record_full,
  output logic [NUM_KEYS-1:0] keys_level,
  output logic [NUM_KEYS-1:0] keys_pressed,
  output logic [NUM_KEYS-1:0] keys_released,
  output logic                note_enable,
  output logic [2:0]          mode,
  output logic                mode_start,
  output logic                mode_stop
);

  localparam int NCH = NUM_KEYS + 4;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NCH-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? {NCH{1'b1}} : {NCH{1'b0}};

  typedef enum logic [2:0] {
    MODE_IDLE    = 3'd0,
    MODE_SONG0   = 3'd1,
    MODE_SONG1   = 3'd2,
    MODE_REC     = 3'd3,
    MODE_PLAYREC = 3'd4
  } mode_e;

  logic [NCH-1:0] raw_all;
  logic [NCH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NCH-1:0] s_pressed;
  logic [NCH-1:0] deb_q, deb_d, rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  mode_e mode_q, mode_d;
  logic  start_q, start_d, stop_q, stop_d;
  logic  p0, p1, pr, pp;

  // Channel order: music keys, then playSong0, playSong1, makeRecording, playRecording.
  assign raw_all = {raw_playRecording, raw_makeRecording, raw_playSong1, raw_playSong0, raw_keys};

  always_comb begin
    sync1_d   = raw_all;
    sync2_d   = sync1_q;
    s_pressed = sync2_q ^ IDLE_LVL;
    deb_d     = deb_q;
    rise_d    = '0;
    fall_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      // Any cycle where s matches the accepted level discards the accumulated run.
      if (s_pressed[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i]  = s_pressed[i];
          rise_d[i] = s_pressed[i];
          fall_d[i] = ~s_pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge max10Board_50MhzClock) begin
    if (!reset_n) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      deb_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign p0 = rise_q[NUM_KEYS];
  assign p1 = rise_q[NUM_KEYS+1];
  assign pr = rise_q[NUM_KEYS+2];
  assign pp = rise_q[NUM_KEYS+3];

  always_comb begin
    mode_d  = mode_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    case (mode_q)
      MODE_IDLE: begin
        if (p0)      mode_d = MODE_SONG0;
        else if (p1) mode_d = MODE_SONG1;
        else if (pr) mode_d = MODE_REC;
        else if (pp) mode_d = MODE_PLAYREC;
        start_d = p0 | p1 | pr | pp;
      end
      MODE_SONG0: if (p0 || song_done) begin
        mode_d = MODE_IDLE;
        stop_d = 1'b1;
      end
      MODE_SONG1: if (p1 || song_done) begin
        mode_d = MODE_IDLE;
        stop_d = 1'b1;
      end
      MODE_REC: if (pr || record_full) begin
        mode_d = MODE_IDLE;
        stop_d = 1'b1;
      end
      MODE_PLAYREC: if (pp || song_done) begin
        mode_d = MODE_IDLE;
        stop_d = 1'b1;
      end
      default: mode_d = MODE_IDLE;
    endcase
  end

  always_ff @(posedge max10Board_50MhzClock) begin
    if (!reset_n) begin
      mode_q  <= MODE_IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  // Button levels and release pulses only matter inside this block.
  logic unused_btn;
  assign unused_btn = ^{deb_q[NCH-1:NUM_KEYS], fall_q[NCH-1:NUM_KEYS]};

  assign keys_level    = deb_q[NUM_KEYS-1:0];
  assign keys_pressed  = rise_q[NUM_KEYS-1:0];
  assign keys_released = fall_q[NUM_KEYS-1:0];
  assign mode          = mode_q;
  assign mode_start    = start_q;
  assign mode_stop     = stop_q;
  assign note_enable   = (mode_q == MODE_IDLE) || (mode_q == MODE_REC);

endmodule

// File: tb/tb_musicbox_input_conditioner.sv
// tb/tb_musicbox_input_conditioner.sv - directed and randomized bench with a behavioural reference model.
module tb_musicbox_input_conditioner;

  localparam int NK  = 6;
  localparam int DEB = 4;
  localparam int NCH = NK + 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NK-1:0] raw_keys;
  logic          raw_playSong0, raw_playSong1, raw_makeRecording, raw_playRecording;
  logic          song_done, record_full;
  logic [NK-1:0] keys_level, keys_pressed, keys_released;
  logic          note_enable, mode_start, mode_stop;
  logic [2:0]    mode;

  musicbox_input_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1)) dut (
    .max10Board_50MhzClock(clk),
    .reset_n(reset_n),
    .raw_keys(raw_keys),
    .raw_playSong0(raw_playSong0),
    .raw_playSong1(raw_playSong1),
    .raw_makeRecording(raw_makeRecording),
    .raw_playRecording(raw_playRecording),
    .song_done(song_done),
    .record_full(record_full),
    .keys_level(keys_level),
    .keys_pressed(keys_pressed),
    .keys_released(keys_released),
    .note_enable(note_enable),
    .mode(mode),
    .mode_start(mode_start),
    .mode_stop(mode_stop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pressed-polarity samples delayed two clocks, per-channel streak of disagreeing samples.
  bit [NCH-1:0] m_d1, m_d2, m_lvl, m_rise, m_fall;
  int           m_streak [NCH];
  int           m_mode;
  bit           m_start, m_stop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit [NCH-1:0] raw_v, input bit sd, input bit rf, input bit rst_n);
    int nm;
    bit p0, p1, pr, pp;
    bit [NCH-1:0] s;
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < NCH; i++) m_streak[i] = 0;
      m_mode = 0; m_start = 0; m_stop = 0;
      return;
    end
    p0 = m_rise[NK]; p1 = m_rise[NK+1]; pr = m_rise[NK+2]; pp = m_rise[NK+3];
    nm = m_mode;
    if (m_mode == 0) begin
      if (p0) nm = 1; else if (p1) nm = 2; else if (pr) nm = 3; else if (pp) nm = 4;
    end else if (m_mode == 1 && (p0 || sd)) nm = 0;
    else if (m_mode == 2 && (p1 || sd)) nm = 0;
    else if (m_mode == 3 && (pr || rf)) nm = 0;
    else if (m_mode == 4 && (pp || sd)) nm = 0;
    m_start = (m_mode == 0) && (nm != 0);
    m_stop  = (m_mode != 0) && (nm == 0);
    m_mode  = nm;
    s = m_d2;
    m_rise = '0; m_fall = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s[i] != m_lvl[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DEB) begin
          m_lvl[i] = s[i];
          m_rise[i] = s[i];
          m_fall[i] = !s[i];
          m_streak[i] = 0;
        end
      end else m_streak[i] = 0;
    end
    m_d2 = m_d1;
    m_d1 = ~raw_v;
  endtask

  task automatic step();
    bit [NCH-1:0] raw_v;
    raw_v = {raw_playRecording, raw_makeRecording, raw_playSong1, raw_playSong0, raw_keys};
    model_edge(raw_v, song_done, record_full, reset_n);
    @(posedge clk);
    #1;
    chk("keys_level", 32'(keys_level), 32'(m_lvl[NK-1:0]));
    chk("keys_pressed", 32'(keys_pressed), 32'(m_rise[NK-1:0]));
    chk("keys_released", 32'(keys_released), 32'(m_fall[NK-1:0]));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("mode_start", 32'(mode_start), 32'(m_start));
    chk("mode_stop", 32'(mode_stop), 32'(m_stop));
    chk("note_enable", 32'(note_enable), 32'((m_mode == 0) || (m_mode == 3)));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0; raw_keys = '1;
    raw_playSong0 = 1'b1; raw_playSong1 = 1'b1; raw_makeRecording = 1'b1; raw_playRecording = 1'b1;
    song_done = 1'b0; record_full = 1'b0;
    steps(2);
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_note_enable", 32'(note_enable), 32'd1);
    reset_n = 1'b1;
    steps(20);
    chk("idle_level", 32'(keys_level), 32'd0);

    // Key 2 press: level rises exactly DEB+2 clocks after the raw change.
    raw_keys[2] = 1'b0;
    steps(5);
    chk("key2_not_yet", 32'(keys_level[2]), 32'd0);
    step();
    chk("key2_level_lat", 32'(keys_level[2]), 32'd1);
    chk("key2_pressed_pulse", 32'(keys_pressed[2]), 32'd1);
    step();
    chk("key2_pulse_width", 32'(keys_pressed[2]), 32'd0);
    raw_keys[2] = 1'b1;
    steps(5);
    chk("key2_still_high", 32'(keys_level[2]), 32'd1);
    step();
    chk("key2_released_pulse", 32'(keys_released[2]), 32'd1);
    steps(3);

    // Glitchy key 0 never qualifies.
    raw_keys[0] = 1'b0; steps(3);
    raw_keys[0] = 1'b1; steps(1);
    raw_keys[0] = 1'b0; steps(3);
    raw_keys[0] = 1'b1; steps(8);
    chk("key0_glitch_level", 32'(keys_level[0]), 32'd0);

    // playSong1, then song_done.
    raw_playSong1 = 1'b0;
    steps(7);
    chk("song1_mode", 32'(mode), 32'd2);
    chk("song1_start", 32'(mode_start), 32'd1);
    chk("song1_note_en", 32'(note_enable), 32'd0);
    raw_playSong1 = 1'b1;
    steps(8);
    song_done = 1'b1; step(); song_done = 1'b0;
    chk("song1_done_mode", 32'(mode), 32'd0);
    chk("song1_done_stop", 32'(mode_stop), 32'd1);
    steps(2);

    // Simultaneous playSong0 + makeRecording: playSong0 wins.
    raw_playSong0 = 1'b0; raw_makeRecording = 1'b0;
    steps(7);
    chk("prio_mode", 32'(mode), 32'd1);
    raw_playSong0 = 1'b1; raw_makeRecording = 1'b1;
    steps(8);
    raw_makeRecording = 1'b0; steps(8); raw_makeRecording = 1'b1; steps(8);
    chk("song0_ignore_rec", 32'(mode), 32'd1);
    raw_playSong0 = 1'b0; steps(7);
    chk("song0_second_press", 32'(mode), 32'd0);
    chk("song0_stop", 32'(mode_stop), 32'd1);
    raw_playSong0 = 1'b1; steps(8);

    // Recording ended by record_full.
    raw_makeRecording = 1'b0; steps(7);
    chk("rec_mode", 32'(mode), 32'd3);
    raw_makeRecording = 1'b1; steps(8);
    record_full = 1'b1; step(); record_full = 1'b0;
    chk("rec_full_mode", 32'(mode), 32'd0);
    steps(2);

    // Reset while in PLAY_RECORDING.
    raw_playRecording = 1'b0; steps(7);
    chk("playrec_mode", 32'(mode), 32'd4);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    chk("reset_mid_mode", 32'(mode), 32'd0);
    chk("reset_mid_stop", 32'(mode_stop), 32'd0);
    raw_playRecording = 1'b1; steps(10);

    // Randomized phase.
    for (int it = 0; it < 400; it++) begin
      int ch, hold;
      ch   = int'($urandom_range(NCH - 1, 0));
      hold = int'($urandom_range(8, 1));
      if (ch < NK) raw_keys[ch] = ~raw_keys[ch];
      else if (ch == NK) raw_playSong0 = ~raw_playSong0;
      else if (ch == NK + 1) raw_playSong1 = ~raw_playSong1;
      else if (ch == NK + 2) raw_makeRecording = ~raw_makeRecording;
      else raw_playRecording = ~raw_playRecording;
      for (int h = 0; h < hold; h++) begin
        song_done   = ($urandom_range(15, 0) == 0);
        record_full = ($urandom_range(15, 0) == 0);
        reset_n     = ($urandom_range(299, 0) != 0);
        step();
      end
      song_done = 1'b0; record_full = 1'b0; reset_n = 1'b1;
    end
    steps(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/musicbox_input_conditioner.md
Name: musicbox_input_conditioner

Overview:
- Front-end stage feeding the MusicBox top level.
- Takes the raw GPIO music keys and the four control buttons, then synchronizes, polarity-normalizes and debounces them.
- Produces clean key levels and one-cycle press/release pulses.
- Runs the UI mode state machine (idle / play song 0 / play song 1 / record / play recording) that the playback and SDRAM recording stages consume.

Parameters:
- NUM_KEYS, 6: number of music-key inputs.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal minimum 2.
- ACTIVE_LOW, 1: 1 = raw inputs are asserted low (pressed = 0); 0 = asserted high.

Ports:
- max10Board_50MhzClock  input  1  sole clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- raw_keys  input  NUM_KEYS  raw GPIO music keys, asynchronous.
- raw_playSong0  input  1  raw button, asynchronous.
- raw_playSong1  input  1  raw button, asynchronous.
- raw_makeRecording  input  1  raw button, asynchronous.
- raw_playRecording  input  1  raw button, asynchronous.
- song_done  input  1  one-cycle pulse from the playback stage: song or recording finished.
- record_full  input  1  one-cycle pulse from the recorder: SDRAM record region exhausted.
- keys_level  output  NUM_KEYS  debounced key state, 1 = pressed.
- keys_pressed  output  NUM_KEYS  one-cycle pulse per key on its debounced 0->1.
- keys_released  output  NUM_KEYS  one-cycle pulse per key on its debounced 1->0.
- note_enable  output  1  high in IDLE and RECORDING (keys may sound).
- mode  output  3  0 IDLE, 1 PLAY_SONG0, 2 PLAY_SONG1, 3 RECORDING, 4 PLAY_RECORDING.
- mode_start  output  1  one-cycle pulse when mode leaves IDLE.
- mode_stop  output  1  one-cycle pulse when mode returns to IDLE.

Behaviour:
- Reset is synchronous: reset_n=0 at a clock edge applies reset values on that edge.
- Reset values:
  - Synchronizer flops = inactive level (1 if ACTIVE_LOW, else 0), so no spurious edge on release.
  - Debounced levels 0, counters 0.
  - All outputs 0; mode = IDLE (0); note_enable = 1.
- Input path (per input, NUM_KEYS+4 channels):
  - 2-FF synchronizer, then invert if ACTIVE_LOW, giving s (1 = pressed).
  - Counter width = $clog2(DEBOUNCE_CYCLES).
  - If s == deb: counter <= 0.
  - If s != deb and counter < DEBOUNCE_CYCLES-1: counter++.
  - If s != deb and counter == DEBOUNCE_CYCLES-1: deb <= s, counter <= 0, rise/fall pulse registered on the same edge.
  - A single-cycle glitch of s resets acceptance; there is no partial credit.
- Latency: a raw change held stable reaches keys_level exactly DEBOUNCE_CYCLES+2 clocks later. Pulses are coincident with the level change and exactly 1 cycle wide.
- Control-button press pulses (p0, p1, pr, pp) feed the FSM only; their levels are not output.
- FSM, registered; mode changes on the edge after the triggering pulse is high:
  - IDLE: p0 -> PLAY_SONG0; p1 -> PLAY_SONG1; pr -> RECORDING; pp -> PLAY_RECORDING.
  - IDLE, simultaneous presses: priority p0 > p1 > pr > pp.
  - PLAY_SONG0 / PLAY_SONG1 / PLAY_RECORDING: the same button's press or song_done -> IDLE. Other buttons are ignored.
  - RECORDING: pr or record_full -> IDLE. Other buttons and song_done are ignored.
  - Exit and entry in one cycle are impossible: a press that stops a mode does not start another.
- mode_start / mode_stop pulse on the same edge the mode register changes.
- note_enable is combinational from mode.
- Keys are always debounced and reported regardless of mode; downstream gates on note_enable.
- Reset mid-operation (mid-debounce or in any mode): next cycle is IDLE with counters 0. No mode_stop pulse is issued.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
- Reset release with all raw inputs 1 -> keys_level=0, mode=0, all pulses 0 for 20 cycles.
- raw_keys[2] 1->0 held -> keys_level[2] rises exactly 6 clocks later; keys_pressed[2] high that one cycle. Key restored to 1 -> keys_released[2] pulses 6 clocks later.
- raw_keys[0] low for 3 cycles, high 1, low 3 -> keys_level[0] never rises, no pulses.
- raw_playSong1 pressed -> mode 0->2 one cycle after the press pulse, mode_start=1, note_enable=0. song_done pulse -> mode=0, mode_stop=1.
- raw_playSong0 and raw_makeRecording pressed the same cycle in IDLE -> mode=1. A record press while in mode 1 is ignored; a second playSong0 press -> mode=0.
- In RECORDING (mode=3), record_full pulse -> mode=0. reset_n=0 for 1 cycle while mode=4 -> mode=0 next edge, mode_stop=0.
